viterbi_ber_monitor: RTL
========================

// Module: viterbi_ber_monitor
// PURPOSE
//  Receive-end checker for the convolutional encoder -> noisy channel -> Viterbi decoder link.
//  Buffers the source bits fed to the encoder and aligns them with the decoder output bits.
//  Compares each aligned pair and keeps bit-error, compared-bit and longest-error-burst statistics.
//  Sits beside the tx/rx loop; drives no datapath.
// PARAMETERS
//  DEPTH      32   reference FIFO entries (power of 2); must cover decoder latency in bits
//  SKIP_BITS  8    leading decoded bits discarded (decoder warm-up/traceback flush)
//  BIT_LIMIT  256  compared bits after which the monitor stops (DONE)
//  CNT_W      16   width of all statistic counters
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  clear_i      in   1      synchronous clear: same effect as rst, one cycle
//  tx_valid_i   in   1      source bit presented to encoder this cycle
//  tx_bit_i     in   1      source bit
//  rx_valid_i   in   1      decoder output bit valid this cycle
//  rx_bit_i     in   1      decoded bit
//  err_pulse_o  out  1      1-cycle pulse, registered, on each counted mismatch
//  err_ct_o     out  CNT_W  mismatching bits counted
//  cmp_ct_o     out  CNT_W  bits compared (after skip)
//  burst_max_o  out  CNT_W  longest run of consecutive mismatches
//  ovf_o        out  1      sticky: push while FIFO full
//  udf_o        out  1      sticky: rx bit with FIFO empty
//  done_o       out  1      high in DONE state
// BEHAVIOUR
//  Reset/clear: all outputs 0, FIFO empty, state IDLE, skip/run counters 0.
//  FSM: IDLE -> SKIP on first rx_valid_i (that bit already counts as skip #1).
//       SKIP -> CMP after SKIP_BITS rx bits consumed (SKIP_BITS=0: IDLE -> CMP directly).
//       CMP -> DONE when cmp_ct reaches BIT_LIMIT; DONE holds until rst/clear_i.
//  Push: tx_valid_i writes tx_bit_i into FIFO in every state except DONE.
//  Pop: each rx_valid_i pops one entry (SKIP and CMP); in CMP pair is compared.
//  Push+pop same cycle: both happen; legal when full (occupancy unchanged, no ovf).
//  Full with push and no pop: bit dropped, ovf_o <= 1. Empty with rx_valid_i: no pop, no compare, udf_o <= 1.
//  Compare latency: stats and err_pulse_o update on the cycle after rx_valid_i.
//  Mismatch: err_ct +1, run +1, burst_max = max(burst_max, run+1). Match: run <= 0.
//  All counters saturate at 2**CNT_W-1; no wrap. FIFO pointers wrap modulo DEPTH, with an extra
//   MSB distinguishing full from empty.
//  In DONE: pushes and pops are ignored and all stats are frozen.
//  rst asserted mid-run: immediate async clear; first post-reset rx bit restarts the SKIP phase.
// CONFIGURATION
//  VITERBI_BER_BURST_EN defined: run counter and burst_max_o are active as above.
//  Not defined: no run logic; burst_max_o tied to 0; other behaviour unchanged.
// STRUCTURE
//  viterbi_pkg: typedef enum logic [1:0] {IDLE, SKIP, CMP, DONE} ber_state_t;
//   also the default CNT_W constant and the saturating-increment function sat_inc.
//  Sub-module ber_ref_fifo (1-bit wide, DEPTH deep, push/pop/full/empty) holds the tx reference.
//  Top level holds the FSM, compare stage and statistic counters.
// TESTING
//  1 Clean loop: 264 tx bits, rx = tx delayed 10 cycles, SKIP_BITS=8
//     -> cmp_ct=256, err_ct=0, done_o=1, ovf_o=udf_o=0.
//  2 Flip rx bit at compared index 100 -> err_ct=1, one err_pulse_o, burst_max=1.
//  3 Flip compared bits 40..43 and 90..91 -> err_ct=6, burst_max=4 (0 without VITERBI_BER_BURST_EN).
//  4 Stall rx; push 33 tx bits with DEPTH=32 -> ovf_o=1 on 33rd push; push+pop while full -> no ovf.
//  5 rx_valid_i before any tx push -> udf_o=1, cmp_ct unchanged.
//  6 Assert rst after 50 compares -> all outputs 0 immediately; rerun of test 1 passes identically.

Source files
------------

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared types and helpers for the Viterbi link BER monitor.
//   ber_state_t - monitor FSM states (IDLE, SKIP, CMP, DONE)
//   BER_CNT_W   - default width of the statistic counters
//   sat_inc     - saturating increment, used with values up to 32 bits wide
package viterbi_pkg;

  localparam int unsigned BER_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } ber_state_t;

  // Increment val and clamp it at max_val. Callers zero-extend narrower counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/ber_ref_fifo.sv
// ber_ref_fifo: 1-bit wide reference FIFO that holds the source bits for the BER monitor.
// Pointers carry one extra MSB, so full and empty can be told apart when the index bits match.
// The head entry is read combinationally. A push while the FIFO is full is dropped unless a
// pop happens in the same cycle.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr_i     - synchronous clear of both pointers
//   push_i    - write din_i
//   din_i     - bit to write
//   pop_i     - discard the head entry
//   dout_o    - head entry
//   full_o    - FIFO full
//   empty_o   - FIFO empty
// DEPTH must be a power of 2 and at least 2.
module ber_ref_fifo #(
  parameter int unsigned DEPTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] mem_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees a slot, so a push is legal even when the FIFO is full.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointer values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage, no reset needed: the pointers decide which entries are valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/viterbi_ber_monitor.sv
// viterbi_ber_monitor: receive-end checker for the encoder -> channel -> Viterbi decoder link.
// Stores the source bits in a reference FIFO and pairs each decoded bit with the oldest stored
// bit. It discards SKIP_BITS leading decoded bits, then compares up to BIT_LIMIT bits and
// counts errors.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   clear_i       - synchronous clear, same effect as rst
//   tx_valid_i/tx_bit_i - source bit going into the encoder
//   rx_valid_i/rx_bit_i - decoded bit
//   err_pulse_o   - one-cycle pulse for each counted mismatch
//   err_ct_o      - count of mismatched bits
//   cmp_ct_o      - count of compared bits
//   burst_max_o   - longest run of consecutive mismatches
//   ovf_o         - sticky: a source bit was dropped because the FIFO was full
//   udf_o         - sticky: a decoded bit arrived while the FIFO was empty
//   done_o        - BIT_LIMIT bits have been compared
// Build option: define VITERBI_BER_BURST_EN to build the run counter and burst_max_o.
// Without it, burst_max_o is tied to 0.
module viterbi_ber_monitor
  import viterbi_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned SKIP_BITS = 8,
  parameter int unsigned BIT_LIMIT = 256,
  parameter int unsigned CNT_W     = BER_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             tx_valid_i,
  input  logic             tx_bit_i,
  input  logic             rx_valid_i,
  input  logic             rx_bit_i,
  output logic             err_pulse_o,
  output logic [CNT_W-1:0] err_ct_o,
  output logic [CNT_W-1:0] cmp_ct_o,
  output logic [CNT_W-1:0] burst_max_o,
  output logic             ovf_o,
  output logic             udf_o,
  output logic             done_o
);

  localparam int unsigned    SKIP_W    = (SKIP_BITS > 1) ? $clog2(SKIP_BITS + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  LIMIT     = CNT_W'(BIT_LIMIT);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_BITS);

  ber_state_t        state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d, skip_inc;
  logic [CNT_W-1:0]  err_ct_q, err_ct_d;
  logic [CNT_W-1:0]  cmp_ct_q, cmp_ct_d;
  logic              err_pulse_q, err_pulse_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
`ifdef VITERBI_BER_BURST_EN
  logic [CNT_W-1:0]  run_q, run_d, run_inc;
  logic [CNT_W-1:0]  burst_q, burst_d;
`endif

  logic active;
  logic push;
  logic pop;
  logic consume;
  logic cmp_en;
  logic mism;
  logic fifo_dout;
  logic fifo_full;
  logic fifo_empty;

  // DONE freezes everything, including the FIFO
  assign active  = (state_q != DONE);
  assign push    = tx_valid_i && active;
  assign pop     = rx_valid_i && active;
  assign consume = pop && !fifo_empty;
  assign mism    = rx_bit_i ^ fifo_dout;

  ber_ref_fifo #(
    .DEPTH (DEPTH)
  ) u_ref_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clear_i),
    .push_i  (push),
    .din_i   (tx_bit_i),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next state, compare and statistics
  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    err_ct_d    = err_ct_q;
    cmp_ct_d    = cmp_ct_q;
    err_pulse_d = 1'b0;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    cmp_en      = 1'b0;
    skip_inc    = skip_q + SKIP_W'(1);
`ifdef VITERBI_BER_BURST_EN
    run_d       = run_q;
    burst_d     = burst_q;
    run_inc     = CNT_W'(sat_inc(32'(run_q), 32'(CNT_MAX)));
`endif

    if (push && fifo_full && !consume) ovf_d = 1'b1;
    if (pop && fifo_empty)             udf_d = 1'b1;

    // Only decoded bits that find a reference entry move the FSM forward
    case (state_q)
      IDLE: begin
        if (consume) begin
          if (SKIP_BITS == 0) begin
            state_d = CMP;
            cmp_en  = 1'b1;
          end else begin
            skip_d  = SKIP_W'(1);
            state_d = (SKIP_BITS == 1) ? CMP : SKIP;
          end
        end
      end
      SKIP: begin
        if (consume) begin
          skip_d = skip_inc;
          if (skip_inc == SKIP_LAST) state_d = CMP;
        end
      end
      CMP: begin
        if (consume) cmp_en = 1'b1;
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase

    if (cmp_en) begin
      cmp_ct_d = CNT_W'(sat_inc(32'(cmp_ct_q), 32'(CNT_MAX)));
      if (mism) begin
        err_ct_d    = CNT_W'(sat_inc(32'(err_ct_q), 32'(CNT_MAX)));
        err_pulse_d = 1'b1;
`ifdef VITERBI_BER_BURST_EN
        run_d = run_inc;
        if (run_inc > burst_q) burst_d = run_inc;
`endif
      end else begin
`ifdef VITERBI_BER_BURST_EN
        run_d = '0;
`endif
      end
    end

    if ((state_d == CMP) && (cmp_ct_d >= LIMIT)) state_d = DONE;
  end

  // State and statistic registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      skip_q      <= '0;
      err_ct_q    <= '0;
      cmp_ct_q    <= '0;
      err_pulse_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
`ifdef VITERBI_BER_BURST_EN
      run_q       <= '0;
      burst_q     <= '0;
`endif
    end else if (clear_i) begin
      state_q     <= IDLE;
      skip_q      <= '0;
      err_ct_q    <= '0;
      cmp_ct_q    <= '0;
      err_pulse_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
`ifdef VITERBI_BER_BURST_EN
      run_q       <= '0;
      burst_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      err_ct_q    <= err_ct_d;
      cmp_ct_q    <= cmp_ct_d;
      err_pulse_q <= err_pulse_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
`ifdef VITERBI_BER_BURST_EN
      run_q       <= run_d;
      burst_q     <= burst_d;
`endif
    end
  end

  assign err_pulse_o = err_pulse_q;
  assign err_ct_o    = err_ct_q;
  assign cmp_ct_o    = cmp_ct_q;
  assign ovf_o       = ovf_q;
  assign udf_o       = udf_q;
  assign done_o      = (state_q == DONE);
`ifdef VITERBI_BER_BURST_EN
  assign burst_max_o = burst_q;
`else
  assign burst_max_o = '0;
`endif

endmodule
